// File: rtl/expr_checker.sv
// Streaming arithmetic-expression recogniser: one ASCII character per valid cycle,
// multi-digit operands, optional '-' and '/', bounded parenthesis nesting.
module expr_checker #(
  parameter int unsigned MAX_DIGITS    = 4,
  parameter int unsigned MAX_DEPTH     = 7,
  parameter bit          ALLOW_SUB_DIV = 1'b1,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DEPTH_W       = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               restart,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   num_cnt
);

  localparam int unsigned DIG_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {StExpect, StNum, StClose, StErr} state_e;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic               lz_q, lz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               err_q, err_d;

  logic is_dig, is_op, is_lp, is_rp;

  always_comb begin
    is_dig = (in >= 8'h30) && (in <= 8'h39);
    is_op  = (in == 8'h2b) || (in == 8'h2a) ||
             (ALLOW_SUB_DIV && ((in == 8'h2d) || (in == 8'h2f)));
    is_lp  = (in == 8'h28);
    is_rp  = (in == 8'h29);
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dig_d   = dig_q;
    lz_d    = lz_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = StExpect;
      depth_d = '0;
      dig_d   = '0;
      lz_d    = 1'b0;
      cnt_d   = '0;
    end else if (in_valid) begin
      // Every ERR transition leaves depth/digit/count registers untouched.
      unique case (state_q)
        StExpect: begin
          if (is_dig) begin
            state_d = StNum;
            dig_d   = DIG_W'(1);
            lz_d    = (in == 8'h30);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end else if (is_lp) begin
            if (depth_q == DEPTH_W'(MAX_DEPTH)) state_d = StErr;
            else depth_d = depth_q + DEPTH_W'(1);
          end else begin
            state_d = StErr;
          end
        end
        StNum: begin
          if (is_dig) begin
            if ((dig_q == DIG_W'(MAX_DIGITS)) || lz_q) state_d = StErr;
            else dig_d = dig_q + DIG_W'(1);
          end else if (is_op) begin
            state_d = StExpect;
          end else if (is_rp) begin
            if (depth_q == '0) begin
              state_d = StErr;
            end else begin
              state_d = StClose;
              depth_d = depth_q - DEPTH_W'(1);
            end
          end else begin
            state_d = StErr;
          end
        end
        StClose: begin
          if (is_op) begin
            state_d = StExpect;
          end else if (is_rp) begin
            if (depth_q == '0) state_d = StErr;
            else depth_d = depth_q - DEPTH_W'(1);
          end else begin
            state_d = StErr;
          end
        end
        StErr: state_d = StErr;
        default: state_d = StErr;
      endcase
    end
    out_d = ((state_d == StNum) || (state_d == StClose)) && (depth_d == '0);
    err_d = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StExpect;
      depth_q <= '0;
      dig_q   <= '0;
      lz_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dig_q   <= dig_d;
      lz_q    <= lz_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out     = out_q;
  assign err     = err_q;
  assign depth   = depth_q;
  assign num_cnt = cnt_q;

endmodule

// File: tb/tb_expr_checker.sv
// Bench for expr_checker: four parameterisations share one stimulus stream; a reference
// model fills a scoreboard queue that a monitor drains, and each test adds targeted checks.
module tb_expr_checker;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       restart;
  logic       in_valid;
  logic [7:0] in;

  logic       o0, o1, o2, o3;
  logic       e0, e1, e2, e3;
  logic [2:0] d0, d2, d3;
  logic [1:0] d1;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  int checks = 0;
  int errors = 0;

  // u0 defaults, u1 MAX_DEPTH=2, u2 MAX_DIGITS=3, u3 no '-' '/' with a 2-bit counter
  expr_checker u0 (.clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid),
                   .in(in), .out(o0), .err(e0), .depth(d0), .num_cnt(c0));
  expr_checker #(.MAX_DEPTH(2)) u1 (.clk(clk), .clr_n(clr_n), .restart(restart),
                   .in_valid(in_valid), .in(in), .out(o1), .err(e1), .depth(d1), .num_cnt(c1));
  expr_checker #(.MAX_DIGITS(3)) u2 (.clk(clk), .clr_n(clr_n), .restart(restart),
                   .in_valid(in_valid), .in(in), .out(o2), .err(e2), .depth(d2), .num_cnt(c2));
  expr_checker #(.ALLOW_SUB_DIV(1'b0), .CNT_W(2)) u3 (.clk(clk), .clr_n(clr_n),
                   .restart(restart), .in_valid(in_valid), .in(in), .out(o3), .err(e3),
                   .depth(d3), .num_cnt(c3));

  always #5 clk = ~clk;

  localparam int P_DIG [4] = '{4, 4, 3, 4};
  localparam int P_DEP [4] = '{7, 2, 7, 7};
  localparam int P_SD  [4] = '{1, 1, 1, 0};
  localparam int P_CMAX[4] = '{255, 255, 255, 3};

  // Model states: 0 EXPECT, 1 NUM, 2 CLOSE, 3 ERR
  int m_st[4], m_dep[4], m_dig[4], m_lz[4], m_cnt[4];

  typedef struct packed {
    logic [3:0]      out;
    logic [3:0]      err;
    logic [3:0][7:0] dep;
    logic [3:0][7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  logic [3:0]      a_out, a_err;
  logic [3:0][7:0] a_dep, a_cnt;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0; m_dep[i] = 0; m_dig[i] = 0; m_lz[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [7:0] c);
    logic dig, op, lp, rp;
    dig = (c >= "0") && (c <= "9");
    op  = (c == "+") || (c == "*") || ((P_SD[i] == 1) && ((c == "-") || (c == "/")));
    lp  = (c == "(");
    rp  = (c == ")");
    case (m_st[i])
      0: begin
        if (dig) begin
          m_st[i] = 1; m_dig[i] = 1; m_lz[i] = (c == "0") ? 1 : 0;
          if (m_cnt[i] < P_CMAX[i]) m_cnt[i]++;
        end else if (lp) begin
          if (m_dep[i] == P_DEP[i]) m_st[i] = 3;
          else m_dep[i]++;
        end else m_st[i] = 3;
      end
      1: begin
        if (dig) begin
          if (m_dig[i] == P_DIG[i] || m_lz[i] == 1) m_st[i] = 3;
          else m_dig[i]++;
        end else if (op) m_st[i] = 0;
        else if (rp) begin
          if (m_dep[i] == 0) m_st[i] = 3;
          else begin m_dep[i]--; m_st[i] = 2; end
        end else m_st[i] = 3;
      end
      2: begin
        if (op) m_st[i] = 0;
        else if (rp) begin
          if (m_dep[i] == 0) m_st[i] = 3;
          else m_dep[i]--;
        end else m_st[i] = 3;
      end
      default: ;
    endcase
  endtask

  // Drive one cycle, push the model's prediction, return 2 time units after the edge.
  task automatic drive(input logic [7:0] ch, input logic v, input logic rs);
    exp_t e;
    in = ch; in_valid = v; restart = rs;
    if (rs) model_reset();
    else if (v) for (int i = 0; i < 4; i++) model_step(i, ch);
    for (int i = 0; i < 4; i++) begin
      e.out[i] = ((m_st[i] == 1 || m_st[i] == 2) && m_dep[i] == 0);
      e.err[i] = (m_st[i] == 3);
      e.dep[i] = 8'(m_dep[i]);
      e.cnt[i] = 8'(m_cnt[i]);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_e  = exp_q.pop_front();
      a_out = {o3, o2, o1, o0};
      a_err = {e3, e2, e1, e0};
      a_dep = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
      a_cnt = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
      for (int k = 0; k < 4; k++) begin
        checks += 4;
        if (a_out[k] !== sb_e.out[k]) begin
          errors++; $display("FAIL sb_out u%0d got %b exp %b", k, a_out[k], sb_e.out[k]);
        end
        if (a_err[k] !== sb_e.err[k]) begin
          errors++; $display("FAIL sb_err u%0d got %b exp %b", k, a_err[k], sb_e.err[k]);
        end
        if (a_dep[k] !== sb_e.dep[k]) begin
          errors++; $display("FAIL sb_depth u%0d got %0d exp %0d", k, a_dep[k], sb_e.dep[k]);
        end
        if (a_cnt[k] !== sb_e.cnt[k]) begin
          errors++; $display("FAIL sb_cnt u%0d got %0d exp %0d", k, a_cnt[k], sb_e.cnt[k]);
        end
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({o0, o1, o2, o3, e0, e1, e2, e3, d0, d1, d2, d3, c0, c1, c2, c3} !== '0) begin
      errors++;
      $display("FAIL reset got out=%b%b%b%b err=%b%b%b%b exp all zero", o0, o1, o2, o3,
               e0, e1, e2, e3);
    end
  endtask

  task automatic test_basic();
    string s = "12+3";
    logic exp_o[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(s[i], 1'b1, 1'b0);
      checks++;
      if (o0 !== exp_o[i]) begin
        errors++; $display("FAIL basic_out[%0d] got %b exp %b", i, o0, exp_o[i]);
      end
    end
    checks++;
    if (c0 !== 8'd2 || e0 !== 1'b0) begin
      errors++; $display("FAIL basic_end got cnt=%0d err=%b exp cnt=2 err=0", c0, e0);
    end
  endtask

  task automatic test_nesting();
    string s = "((5)*6)";
    int exp_d[7] = '{1, 2, 2, 1, 1, 1, 0};
    drive(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(s[i], 1'b1, 1'b0);
      checks++;
      if (d0 !== 3'(exp_d[i]) || o0 !== (i == 6)) begin
        errors++;
        $display("FAIL nest[%0d] got depth=%0d out=%b exp depth=%0d out=%b", i, d0, o0,
                 exp_d[i], (i == 6));
      end
    end
  endtask

  task automatic test_max_depth();
    drive(8'h00, 1'b0, 1'b1);
    send("(((");
    checks++;
    if (e1 !== 1'b1 || d1 !== 2'd2) begin
      errors++; $display("FAIL depth_lim got err=%b depth=%0d exp err=1 depth=2", e1, d1);
    end
    send("1)");
    checks++;
    if (e1 !== 1'b1 || d1 !== 2'd2 || o1 !== 1'b0 || c1 !== 8'd0) begin
      errors++;
      $display("FAIL depth_absorb got err=%b depth=%0d out=%b cnt=%0d exp 1,2,0,0",
               e1, d1, o1, c1);
    end
  endtask

  task automatic test_max_digits();
    drive(8'h00, 1'b0, 1'b1);
    send("999");
    checks++;
    if (o2 !== 1'b1 || e2 !== 1'b0) begin
      errors++; $display("FAIL digits3 got out=%b err=%b exp out=1 err=0", o2, e2);
    end
    send("9");
    checks++;
    if (e2 !== 1'b1 || o0 !== 1'b1) begin
      errors++; $display("FAIL digits4 got u2 err=%b u0 out=%b exp 1,1", e2, o0);
    end
    drive(8'h00, 1'b0, 1'b1);
    send("0");
    checks++;
    if (o2 !== 1'b1 || e2 !== 1'b0) begin
      errors++; $display("FAIL zero got out=%b err=%b exp out=1 err=0", o2, e2);
    end
    send("5");
    checks++;
    if (e2 !== 1'b1 || e0 !== 1'b1) begin
      errors++; $display("FAIL lead_zero got err=%b/%b exp 1/1", e2, e0);
    end
  endtask

  task automatic test_sub_div();
    drive(8'h00, 1'b0, 1'b1);
    send("4-");
    checks++;
    if (e3 !== 1'b1 || e0 !== 1'b0) begin
      errors++; $display("FAIL nosub got u3 err=%b u0 err=%b exp 1,0", e3, e0);
    end
    send("2");
    checks++;
    if (o0 !== 1'b1) begin
      errors++; $display("FAIL sub got out=%b exp 1", o0);
    end
  endtask

  task automatic test_invalid_strings();
    string bad[7] = '{"07", "+1", "1+", "(1", "1)", "()", "1("};
    for (int i = 0; i < 7; i++) begin
      drive(8'h00, 1'b0, 1'b1);
      send(bad[i]);
      checks++;
      if (o0 !== 1'b0) begin
        errors++; $display("FAIL invalid[%0d] got out=%b exp 0", i, o0);
      end
    end
  endtask

  task automatic test_hold_and_saturate();
    drive(8'h00, 1'b0, 1'b1);
    send("1+2+3");
    drive("+", 1'b0, 1'b0);
    drive("x", 1'b0, 1'b0);
    send("+4/5");
    checks++;
    if (c3 !== 2'd3 || c0 !== 8'd5 || o0 !== 1'b1) begin
      errors++;
      $display("FAIL saturate got c3=%0d c0=%0d out=%b exp 3,5,1", c3, c0, o0);
    end
  endtask

  task automatic test_restart();
    drive(8'h00, 1'b0, 1'b1);
    send("1)");
    drive("x", 1'b1, 1'b1);
    checks++;
    if ({o0, e0, d0, c0} !== '0) begin
      errors++;
      $display("FAIL restart got out=%b err=%b depth=%0d cnt=%0d exp 0", o0, e0, d0, c0);
    end
    send("8");
    checks++;
    if (o0 !== 1'b1 || c0 !== 8'd1) begin
      errors++; $display("FAIL after_restart got out=%b cnt=%0d exp 1,1", o0, c0);
    end
  endtask

  task automatic test_async_clear();
    send("+(2");
    send("(1+(2");
    #3;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({o0, e0, d0, c0, e1, d1} !== '0) begin
      errors++;
      $display("FAIL async_clr got out=%b err=%b depth=%0d cnt=%0d exp 0", o0, e0, d0, c0);
    end
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    send("3");
    checks++;
    if (o0 !== 1'b1 || c0 !== 8'd1 || e0 !== 1'b0) begin
      errors++; $display("FAIL after_clr got out=%b cnt=%0d err=%b exp 1,1,0", o0, c0, e0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clr_n = 1'b1; restart = 1'b0; in_valid = 1'b0; in = 8'h00;
    model_reset();
    #1 clr_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    clr_n = 1'b1;
    test_basic();
    test_nesting();
    test_max_depth();
    test_max_digits();
    test_sub_div();
    test_invalid_strings();
    test_hold_and_saturate();
    test_restart();
    test_async_clear();
    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
